motion_cmd_arbiter: RTL

Shares the motor driver between two command requesters: the IR remote decoder and the UART receiver. Grants ownership to one source at a time and sequences direction changes through duty-cycle ramps. Applies a proximity-based safety brake and an inactivity watchdog. Sits between the command decoders and the PWM/motor driver, replacing direct SEND/MOTOR_STAT steering.

---
 rtl/motion_cmd_arbiter_pkg.sv | 45 ++++
 rtl/motion_cmd_arbiter_duty_ramp.sv | 63 ++++++
 rtl/motion_cmd_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/motion_cmd_arbiter_pkg.sv
// motion_pkg: shared types and constants for the motion command arbiter.
//   motor_cmd_e : 3-bit motor codes understood by the PWM/motor driver
//   arb_state_e : arbiter sequencing states
//   src_e       : command owner encoding as driven on source_o
//   DUTY_MAX    : upper bound for any duty target, in percent
// Optional feature macro used by the arbiter: CMD_WATCHDOG_EN.
package motion_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_FWD   = 3'b001,
    CMD_LEFT  = 3'b010,
    CMD_BRAKE = 3'b011,
    CMD_RIGHT = 3'b100,
    CMD_BACK  = 3'b101
  } motor_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN,
    BRAKE
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    IR   = 2'b01,
    UART = 2'b10
  } src_e;

  localparam int DUTY_MAX = 100;

  // Codes that put the motor in motion (brake and idle are not motion).
  function automatic logic is_motion(input logic [2:0] code);
    return (code == CMD_FWD) || (code == CMD_LEFT) ||
           (code == CMD_RIGHT) || (code == CMD_BACK);
  endfunction

  // 110/111 are reserved and must be dropped entirely.
  function automatic logic is_known(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

endpackage

// File: rtl/motion_cmd_arbiter_duty_ramp.sv
// duty_ramp: free-running ramp prescaler plus saturating duty stepper.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset (clears prescaler and duty)
//   target_i     duty the stepper moves toward, in percent
//   enable_i     allow a step on the prescaler terminal count
//   force_zero_i drop duty to 0 on the next edge, ignoring the ramp
//   duty_o       registered duty, in percent
module duty_ramp #(
  parameter int RAMP_DIV  = 500_000,
  parameter int RAMP_STEP = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] target_i,
  input  logic       enable_i,
  input  logic       force_zero_i,
  output logic [6:0] duty_o
);

  localparam int         CW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [6:0]    duty_q, duty_d;
  logic [7:0]    cur8, tgt8, up8, dn8;

  assign tick = (cnt_q == CW'(RAMP_DIV - 1));

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    cur8   = {1'b0, duty_q};
    tgt8   = {1'b0, target_i};
    up8    = cur8 + STEP8;
    dn8    = cur8 - STEP8;
    duty_d = duty_q;
    if (force_zero_i) begin
      duty_d = '0;
    end else if (enable_i && tick) begin
      // Steps in either direction land exactly on the target rather than
      // overshooting; the down path also guards against wrapping below 0.
      if (cur8 < tgt8) begin
        duty_d = (up8 >= tgt8) ? target_i : up8[6:0];
      end else if (cur8 > tgt8) begin
        duty_d = ((cur8 < STEP8) || (dn8 <= tgt8)) ? target_i : dn8[6:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  assign duty_o = duty_q;

endmodule

// File: rtl/motion_cmd_arbiter.sv
// motion_cmd_arbiter: shares the motor driver between the IR and UART command
// decoders, sequences direction changes through duty ramps, and applies a
// proximity safety brake.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ir_valid_i/ir_cmd_i     IR decoder strobe and motor code
//   uart_valid_i/uart_cmd_i UART decoder strobe and motor code
//   prox_stat_i             distance, smaller is nearer
//   motor_stat_o            motor code to the driver
//   duty_o                  PWM duty, percent
//   source_o                owner: 00 none, 01 IR, 10 UART
//   blocked_o               safety brake active
// Optional feature: define CMD_WATCHDOG_EN to release an inactive owner after
// TIMEOUT_CYC cycles; without it ownership only ends on an accepted idle code.
module motion_cmd_arbiter
  import motion_pkg::*;
#(
  parameter int         RAMP_DIV    = 500_000,
  parameter int         RAMP_STEP   = 5,
  parameter int         DUTY_FAST   = 60,
  parameter int         DUTY_SLOW   = 40,
  parameter logic [3:0] PROX_FAR    = 4'd8,
`ifdef CMD_WATCHDOG_EN
  parameter int         TIMEOUT_CYC = 25_000_000,
`endif
  parameter logic [3:0] PROX_NEAR   = 4'd3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ir_valid_i,
  input  logic [2:0] ir_cmd_i,
  input  logic       uart_valid_i,
  input  logic [2:0] uart_cmd_i,
  input  logic [3:0] prox_stat_i,
  output logic [2:0] motor_stat_o,
  output logic [6:0] duty_o,
  output logic [1:0] source_o,
  output logic       blocked_o
);

  localparam logic [6:0] FAST7 = 7'((DUTY_FAST > DUTY_MAX) ? DUTY_MAX : DUTY_FAST);
  localparam logic [6:0] SLOW7 = 7'((DUTY_SLOW > DUTY_MAX) ? DUTY_MAX : DUTY_SLOW);

  arb_state_e state_q, state_d;
  src_e       source_q, source_d;
  logic [2:0] motor_q, motor_d;
  logic [2:0] pend_q, pend_d;
  logic       blocked_q, blocked_d;

  logic       near, in_motion, acc_ir, acc_uart, acc, expire, force_zero;
  logic [2:0] cmd, pend_eff;
  logic [6:0] tgt, duty;

  assign near      = prox_stat_i < PROX_NEAR;
  assign tgt       = (prox_stat_i >= PROX_FAR) ? FAST7 : SLOW7;
  assign in_motion = (state_q == RAMP_UP) || (state_q == RUN) || (state_q == RAMP_DOWN);

  // A forward request is refused outright while an obstacle is near, so it
  // neither claims ownership nor refreshes the watchdog. IR only wins a tie
  // for a free driver when its own command is acceptable.
  assign acc_ir   = ir_valid_i && is_known(ir_cmd_i) &&
                    !((ir_cmd_i == CMD_FWD) && near) &&
                    ((source_q == NONE) || (source_q == IR));
  assign acc_uart = uart_valid_i && is_known(uart_cmd_i) &&
                    !((uart_cmd_i == CMD_FWD) && near) &&
                    ((source_q == UART) || ((source_q == NONE) && !acc_ir));
  assign acc      = acc_ir || acc_uart;
  assign cmd      = acc_ir ? ir_cmd_i : uart_cmd_i;

`ifdef CMD_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog_q, wdog_d;

  always_comb begin
    expire = 1'b0;
    wdog_d = wdog_q + WW'(1);
    if (acc || (source_q == NONE)) begin
      wdog_d = '0;
    end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
      expire = 1'b1;
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    motor_d   = motor_q;
    pend_d    = pend_q;
    source_d  = source_q;
    blocked_d = near ? blocked_q : 1'b0;
    pend_eff  = pend_q;

    if (acc && (source_q == NONE)) source_d = acc_ir ? IR : UART;
    if (expire)                    source_d = NONE;

    if (in_motion && (motor_q == CMD_FWD) && near) begin
      state_d   = BRAKE;
      motor_d   = CMD_BRAKE;
      blocked_d = 1'b1;
    end else if (acc && (cmd == CMD_BRAKE)) begin
      state_d = BRAKE;
      motor_d = CMD_BRAKE;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc && is_motion(cmd)) begin
            state_d = RAMP_UP;
            motor_d = cmd;
          end
        end
        BRAKE: begin
          if (acc && is_motion(cmd)) begin
            state_d = RAMP_UP;
            motor_d = cmd;
          end else if ((acc && (cmd == CMD_IDLE)) || expire) begin
            state_d = IDLE;
            motor_d = CMD_IDLE;
          end
        end
        RAMP_UP, RUN: begin
          if (expire) begin
            state_d = RAMP_DOWN;
            pend_d  = CMD_IDLE;
          end else if (acc && (cmd != motor_q)) begin
            state_d = RAMP_DOWN;
            pend_d  = cmd;
          end else if ((state_q == RAMP_UP) && (duty == tgt)) begin
            state_d = RUN;
          end
        end
        RAMP_DOWN: begin
          // The newest request this cycle already counts for the turnaround.
          if (expire)   pend_eff = CMD_IDLE;
          else if (acc) pend_eff = cmd;
          pend_d = pend_eff;
          if (duty == 7'd0) begin
            state_d = (pend_eff == CMD_IDLE) ? IDLE : RAMP_UP;
            motor_d = pend_eff;
          end
        end
        default: begin
          state_d = IDLE;
          motor_d = CMD_IDLE;
        end
      endcase
    end

    // Reaching IDLE always frees the driver for either source.
    if (state_d == IDLE) source_d = NONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      source_q  <= NONE;
      motor_q   <= CMD_IDLE;
      pend_q    <= CMD_IDLE;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      source_q  <= source_d;
      motor_q   <= motor_d;
      pend_q    <= pend_d;
      blocked_q <= blocked_d;
    end
  end

  // Idle and brake hold duty at zero; entering brake bypasses the ramp.
  assign force_zero = (state_q == IDLE) || (state_q == BRAKE) || (state_d == BRAKE);

  duty_ramp #(
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .target_i     ((state_q == RAMP_DOWN) ? 7'd0 : tgt),
    .enable_i     (1'b1),
    .force_zero_i (force_zero),
    .duty_o       (duty)
  );

  assign motor_stat_o = motor_q;
  assign duty_o       = duty;
  assign source_o     = source_q;
  assign blocked_o    = blocked_q;

endmodule
